// File: rtl/md_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit.
// Holds the mdOP encoding, FSM states and default busy cycle counts.
package md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Codes 9..15 are not defined and behave as MD_NONE.
    function automatic md_op_e md_decode(input logic [3:0] code);
        md_decode = (code <= 4'd8) ? md_op_e'(code) : MD_NONE;
    endfunction

    function automatic logic md_is_arith(input md_op_e op);
        md_is_arith = (op == MD_MULT) || (op == MD_MULTU) ||
                      (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_calc.sv
// md_calc: combinational 64-bit result generator for mult/multu/div/divu.
// Ports: op (decoded), a/b operands; hi/lo result halves, dz = divide by zero.
import md_unit_pkg::*;

module md_calc (
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dz
);

    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic        [31:0] b_safe;
    logic signed [31:0] s_quo;
    logic signed [31:0] s_rem;
    logic        [31:0] u_quo;
    logic        [31:0] u_rem;
    logic               ovf;

    assign s_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign u_prod = {32'd0, a} * {32'd0, b};

    // Substitute a divisor of 1 so the divider never sees zero;
    // the result is discarded via dz anyway.
    assign b_safe = (b == 32'd0) ? 32'd1 : b;
    assign s_quo  = $signed(a) / $signed(b_safe);
    assign s_rem  = $signed(a) % $signed(b_safe);
    assign u_quo  = a / b_safe;
    assign u_rem  = a % b_safe;

    // Most-negative / -1 overflows; architected as quotient 0x80000000, rem 0.
    assign ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    always_comb begin
        hi = '0;
        lo = '0;
        dz = 1'b0;
        unique case (op)
            MD_MULT: begin
                hi = s_prod[63:32];
                lo = s_prod[31:0];
            end
            MD_MULTU: begin
                hi = u_prod[63:32];
                lo = u_prod[31:0];
            end
            MD_DIV: begin
                dz = (b == 32'd0);
                hi = ovf ? 32'd0 : s_rem;
                lo = ovf ? 32'h8000_0000 : s_quo;
            end
            MD_DIVU: begin
                dz = (b == 32'd0);
                hi = u_rem;
                lo = u_quo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with HI/LO, busy sequencing and stall.
// Ports: clk, reset (sync, high), mdOP, A, B, D_md in; start, busy, mdStall, HI, LO, mdOut out.
import md_unit_pkg::*;

module md_unit #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdOP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        D_md,
    output logic        start,
    output logic        busy,
    output logic        mdStall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] mdOut
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW_RAW  = $clog2(MAX_CYC + 1);
    localparam int CW      = (CW_RAW > 4) ? CW_RAW : 4;

    md_op_e      op;
    md_state_e   state, state_n;
    logic [CW-1:0] count, count_n;
    logic [31:0] t_hi, t_hi_n;
    logic [31:0] t_lo, t_lo_n;
    logic        t_dz, t_dz_n;
    logic [31:0] hi_q, hi_n;
    logic [31:0] lo_q, lo_n;
    logic [31:0] c_hi, c_lo;
    logic        c_dz;
    logic        is_mul;

    assign op     = md_decode(mdOP);
    assign is_mul = (op == MD_MULT) || (op == MD_MULTU);

    md_calc u_calc (
        .op (op),
        .a  (A),
        .b  (B),
        .hi (c_hi),
        .lo (c_lo),
        .dz (c_dz)
    );

    assign busy    = (state == S_RUN);
    assign start   = md_is_arith(op) && !busy;
    assign mdStall = D_md && (start || busy);
    assign HI      = hi_q;
    assign LO      = lo_q;

    always_comb begin
        mdOut = '0;
        unique case (1'b1)
            op == MD_MFHI: mdOut = hi_q;
            op == MD_MFLO: mdOut = lo_q;
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        count_n = count;
        t_hi_n  = t_hi;
        t_lo_n  = t_lo;
        t_dz_n  = t_dz;
        hi_n    = hi_q;
        lo_n    = lo_q;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    t_hi_n  = c_hi;
                    t_lo_n  = c_lo;
                    t_dz_n  = c_dz;
                    count_n = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    state_n = S_RUN;
                end else if (op == MD_MTHI) begin
                    hi_n = A;
                end else if (op == MD_MTLO) begin
                    lo_n = A;
                end
            end
            S_RUN: begin
                // mdOP is ignored entirely while running.
                count_n = count - CW'(1);
                if (count == CW'(1)) begin
                    state_n = S_IDLE;
                    if (!t_dz) begin
                        hi_n = t_hi;
                        lo_n = t_lo;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
            t_hi  <= '0;
            t_lo  <= '0;
            t_dz  <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
            t_hi  <= t_hi_n;
            t_lo  <= t_lo_n;
            t_dz  <= t_dz_n;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
        end
    end

endmodule
